// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator key-sequence driver.
package calc_pkg;

  // Operand width and number of BCD digits needed for the largest legal operand.
  localparam int BIN_W      = 27;
  localparam int BCD_DIGITS = 8;

  // Largest operand the calculator keypad can enter (eight decimal digits).
  localparam logic [BIN_W-1:0] MAX_OPERAND = 27'd99999999;

  // Key codes for the non-digit keys.
  localparam logic [3:0] KEY_ADD  = 4'b1010;
  localparam logic [3:0] KEY_SUB  = 4'b1011;
  localparam logic [3:0] KEY_MUL  = 4'b1100;
  localparam logic [3:0] KEY_EQ   = 4'b1110;
  localparam logic [3:0] KEY_NONE = 4'b1111;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_MUL     = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_sel_e;

  typedef enum logic [2:0] {
    IDLE,
    CONV_A,
    SEND_A,
    SEND_OP,
    CONV_B,
    SEND_B,
    SEND_EQ,
    FINISH
  } state_e;

  // Eight BCD digits, digit 0 is the least significant.
  typedef logic [BCD_DIGITS-1:0][3:0] bcd_t;

  // Request captured at acceptance; bad marks an out-of-range or illegal request.
  typedef struct packed {
    logic [BIN_W-1:0] a;
    logic [BIN_W-1:0] b;
    op_sel_e          op;
    logic             bad;
  } req_t;

  // Operator key for a legal op_sel; illegal requests never reach the keypad.
  function automatic logic [3:0] op_key(input op_sel_e op);
    logic [3:0] key;
    case (op)
      OP_ADD:  key = KEY_ADD;
      OP_SUB:  key = KEY_SUB;
      OP_MUL:  key = KEY_MUL;
      default: key = KEY_NONE;
    endcase
    return key;
  endfunction

  // Index of the most significant non-zero digit; zero yields index 0 so a
  // zero operand still sends a single '0' key.
  function automatic logic [2:0] msd_index(input bcd_t v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (v[i] != 4'd0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// start is taken while idle; busy covers the BIN_W iterations and done
// marks the cycle in which the final iteration is applied.
module bin2bcd
  import calc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output bcd_t             bcd_o
);

  localparam logic [4:0] ITERS = 5'(BIN_W);

  logic [4:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  bcd_t             bcd_q, bcd_d;
  bcd_t             adj;

  // Load on start, otherwise apply one add-3-then-shift step per cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    end
    if (start_i && cnt_q == 5'd0) begin
      cnt_d = ITERS;
      bin_d = bin_i;
      bcd_d = '0;
    end else if (cnt_q != 5'd0) begin
      cnt_d          = cnt_q - 5'd1;
      {bcd_d, bin_d} = {adj, bin_q} << 1;
    end
  end

  // Iteration counter and shift registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: these are plain registers, not a RAM, so clearing them on reset is cheap and intended.
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  assign busy_o = (cnt_q != 5'd0);
  assign done_o = (cnt_q == 5'd1);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_cmd_driver.sv
// Turns an arithmetic request into the key-press sequence a calculator
// expects: digits of A, operator, digits of B, equals. Each key is held for
// HOLD_CYCLES and followed by GAP_CYCLES of IDLE_CMD.
module calc_cmd_driver
  import calc_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter logic [3:0]  IDLE_CMD    = 4'b1111
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [BIN_W-1:0] op_a,
  input  logic [BIN_W-1:0] op_b,
  input  logic [1:0]       op_sel,
  output logic [3:0]       cmd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One key slot is HOLD_CYCLES of the key plus GAP_CYCLES of IDLE_CMD.
  localparam int unsigned        CNT_W    = $clog2(HOLD_CYCLES + GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0]   HOLD_END = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   KEY_END  = CNT_W'(HOLD_CYCLES + GAP_CYCLES - 1);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       sent_q, sent_d;

  logic             conv_start, conv_busy, conv_done;
  logic [BIN_W-1:0] conv_bin;
  bcd_t             bcd;
  logic [2:0]       msd;
  logic [3:0]       key;
  logic             key_active;
  logic             key_last;
  logic             illegal;

  // The single converter serves A during CONV_A and B during CONV_B.
  assign conv_bin = (state_q == CONV_B) ? req_q.b : req_q.a;
  assign msd      = msd_index(bcd);
  assign key_last = (tick_q == KEY_END);
  assign illegal  = (op_a > MAX_OPERAND) || (op_b > MAX_OPERAND) ||
                    (op_sel == 2'b11);

  bin2bcd u_bin2bcd (
    .clock   (clock),
    .reset   (reset),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Next-state, key selection and Moore outputs.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    tick_d     = tick_q;
    sent_d     = sent_q;
    conv_start = 1'b0;
    key        = IDLE_CMD;
    key_active = 1'b0;
    req_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    cmd        = IDLE_CMD;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          req_d.a   = op_a;
          req_d.b   = op_b;
          req_d.op  = op_sel_e'(op_sel);
          req_d.bad = illegal;
          state_d   = illegal ? FINISH : CONV_A;
        end
      end

      CONV_A, CONV_B: begin
        // Kick the converter on the first cycle; it stays busy until done.
        conv_start = !conv_busy;
        if (conv_done) begin
          sent_d  = 3'd0;
          tick_d  = '0;
          state_d = (state_q == CONV_A) ? SEND_A : SEND_B;
        end
      end

      SEND_A, SEND_B: begin
        key_active = 1'b1;
        key        = bcd[msd - sent_q];
        if (key_last) begin
          if (sent_q == msd) begin
            state_d = (state_q == SEND_A) ? SEND_OP : SEND_EQ;
          end else begin
            sent_d = sent_q + 3'd1;
          end
        end
      end

      SEND_OP: begin
        key_active = 1'b1;
        key        = op_key(req_q.op);
        if (key_last) state_d = CONV_B;
      end

      SEND_EQ: begin
        key_active = 1'b1;
        key        = KEY_EQ;
        if (key_last) state_d = FINISH;
      end

      FINISH: begin
        done    = !req_q.bad;
        err     = req_q.bad;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Shared hold/gap timing for every key slot.
    if (key_active) begin
      tick_d = key_last ? '0 : tick_q + CNT_W'(1);
      if (tick_q < HOLD_END) cmd = key;
    end
  end

  // FSM state, captured request and key timing registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      tick_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tick_q  <= tick_d;
      sent_q  <= sent_d;
    end
  end

endmodule
